vga_timing_ctrl: RTL and testbench

//   Raster sequencer for the VGA datapath inside tt_um_vga_MaoyuanCai_TinyTapeout.
//   - Generates hsync/vsync, display_on and the pixel coordinates hpos/vpos.
//   - Emits line/frame start strobes.
//   - Pixel-colour logic consumes hpos/vpos/display_on; syncs drive uo_out directly.
//   - Default timing is 640x480@60 Hz with a 25.175 MHz clk.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_seq.sv | 100 ++++++++++
 rtl/vga_timing_ctrl.sv | 128 ++++++++++++
 tb/tb_vga_timing_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster sequencer.
//   phase_e  : per-axis phase (active video, front porch, sync pulse, back porch)
//   DEF_*    : default 640x480@60 Hz timing (25.175 MHz pixel clock)
//   total()  : length of a full line or frame from its four phase lengths
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CNT_W    = 10;

    function automatic int total(input int active, input int front,
                                 input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_seq.sv
// One raster axis: position counter plus ACTIVE->FRONT->SYNC->BACK phase FSM.
// Ports:
//   i_clk, i_rst_n  pixel clock, asynchronous active-low reset
//   i_step          advance the axis by one position
//   o_pos           current position, 0..TOTAL-1 (reset value TOTAL-1)
//   o_wrap          current position is the last one; the next step wraps to 0
//   o_in_active     phase after this cycle's step will be ACTIVE
//   o_in_sync       phase after this cycle's step will be SYNC
// o_in_active/o_in_sync look at the next state so the parent can register them
// and keep them aligned with o_pos after the same clock edge.
module vga_axis_seq
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int W      = DEF_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_step,
    output logic [W-1:0] o_pos,
    output logic         o_wrap,
    output logic         o_in_active,
    output logic         o_in_sync
);

    localparam int TOTAL = total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [W-1:0] POS_LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_LAST = W'(ACTIVE - 1);
    localparam logic [W-1:0] FRONT_LAST  = W'(FRONT - 1);
    localparam logic [W-1:0] SYNC_LAST   = W'(SYNC - 1);
    localparam logic [W-1:0] BACK_LAST   = W'(BACK - 1);

    // A zero-length phase would never be left, so refuse to elaborate it.
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_len
        $error("vga_axis_seq: every phase length must be at least 1");
    end

    logic [W-1:0] r_pos;
    logic [W-1:0] r_cnt;
    phase_e       r_phase;

    logic [W-1:0] w_pos_next;
    logic [W-1:0] w_cnt_next;
    logic [W-1:0] w_len_last;
    phase_e       w_phase_next;

    always_comb begin
        case (r_phase)
            PH_ACTIVE: w_len_last = ACTIVE_LAST;
            PH_FRONT:  w_len_last = FRONT_LAST;
            PH_SYNC:   w_len_last = SYNC_LAST;
            default:   w_len_last = BACK_LAST;
        endcase
    end

    // Phase changes when the in-phase counter reaches its length-1; the phase
    // lengths sum to TOTAL, so BACK->ACTIVE coincides with the position wrap.
    always_comb begin
        w_pos_next   = r_pos;
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        if (i_step) begin
            w_pos_next = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
            if (r_cnt == w_len_last) begin
                w_cnt_next = '0;
                case (r_phase)
                    PH_ACTIVE: w_phase_next = PH_FRONT;
                    PH_FRONT:  w_phase_next = PH_SYNC;
                    PH_SYNC:   w_phase_next = PH_BACK;
                    default:   w_phase_next = PH_ACTIVE;
                endcase
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Reset parks the axis on its last position (end of back porch) so the
    // first step lands on position 0 at the start of the active phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos   <= POS_LAST;
            r_cnt   <= BACK_LAST;
            r_phase <= PH_BACK;
        end else begin
            r_pos   <= w_pos_next;
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
        end
    end

    assign o_pos       = r_pos;
    assign o_wrap      = (r_pos == POS_LAST);
    assign o_in_active = (w_phase_next == PH_ACTIVE);
    assign o_in_sync   = (w_phase_next == PH_SYNC);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: hsync/vsync, display_on, pixel coordinates and
// line/frame start strobes. Default timing is 640x480@60 Hz.
// Ports:
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_ena          advance enable; 0 freezes the raster
//   o_hpos/o_vpos  current column/line
//   o_hsync/vsync  sync outputs, equal to SYNC_POL only during the sync phase
//   o_display_on   1 while inside the visible area
//   o_line_start   1 while hpos==0 (only on the cycle the raster arrives there)
//   o_frame_start  1 while hpos==0 && vpos==0 (same rule)
//   o_frame_cnt    8-bit frame counter, present only when the macro
//                  VGA_TIMING_FRAMECNT_EN is defined
// All outputs are registers loaded from next-state decode, so they all refer
// to the same (hpos, vpos) with no extra latency.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CNT_W    = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    output logic [CNT_W-1:0] o_hpos,
    output logic [CNT_W-1:0] o_vpos,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_display_on,
    output logic             o_line_start,
`ifdef VGA_TIMING_FRAMECNT_EN
    output logic             o_frame_start,
    output logic [7:0]       o_frame_cnt
`else
    output logic             o_frame_start
`endif
);

    logic w_h_wrap, w_h_active, w_h_sync;
    logic w_v_wrap, w_v_active, w_v_sync;
    logic w_line_next, w_frame_next;

    logic r_hsync, r_vsync, r_display_on, r_line_start, r_frame_start;

    // The vertical axis steps exactly when the horizontal one wraps to column 0.
    assign w_line_next  = i_ena && w_h_wrap;
    assign w_frame_next = w_line_next && w_v_wrap;

    vga_axis_seq #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .W      (CNT_W)
    ) u_h_axis (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_step      (i_ena),
        .o_pos       (o_hpos),
        .o_wrap      (w_h_wrap),
        .o_in_active (w_h_active),
        .o_in_sync   (w_h_sync)
    );

    vga_axis_seq #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .W      (CNT_W)
    ) u_v_axis (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_step      (w_line_next),
        .o_pos       (o_vpos),
        .o_wrap      (w_v_wrap),
        .o_in_active (w_v_active),
        .o_in_sync   (w_v_sync)
    );

    // With ena low the next-state decode equals the current state, so levels
    // hold while the strobes drop because no wrap is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_display_on  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            r_display_on  <= w_h_active && w_v_active;
            r_line_start  <= w_line_next;
            r_frame_start <= w_frame_next;
        end
    end

    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_display_on  = r_display_on;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [7:0] r_frame_cnt;

    // Counts alongside frame_start, so it already reads 1 in the first frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_next) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl.
// dutD runs the default 640x480 timing for line-level behaviour; dutS uses a
// tiny raster (15x12, active-high syncs, 4-bit counters) so whole frames and
// the 256-frame counter wrap fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstD = 1'b0, enaD = 1'b1;
    logic [9:0] hposD, vposD;
    logic       hsyncD, vsyncD, deD, lsD, fsD;

    logic       rstS = 1'b0, enaS = 1'b1;
    logic [3:0] hposS, vposS;
    logic       hsyncS, vsyncS, deS, lsS, fsS;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [7:0] frameCntD, frameCntS;
`endif

    vga_timing_ctrl dutD (
        .i_clk         (clk),
        .i_rst_n       (rstD),
        .i_ena         (enaD),
        .o_hpos        (hposD),
        .o_vpos        (vposD),
        .o_hsync       (hsyncD),
        .o_vsync       (vsyncD),
        .o_display_on  (deD),
        .o_line_start  (lsD),
`ifdef VGA_TIMING_FRAMECNT_EN
        .o_frame_start (fsD),
        .o_frame_cnt   (frameCntD)
`else
        .o_frame_start (fsD)
`endif
    );

    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL (1'b1), .CNT_W (4)
    ) dutS (
        .i_clk         (clk),
        .i_rst_n       (rstS),
        .i_ena         (enaS),
        .o_hpos        (hposS),
        .o_vpos        (vposS),
        .o_hsync       (hsyncS),
        .o_vsync       (vsyncS),
        .o_display_on  (deS),
        .o_line_start  (lsS),
`ifdef VGA_TIMING_FRAMECNT_EN
        .o_frame_start (fsS),
        .o_frame_cnt   (frameCntS)
`else
        .o_frame_start (fsS)
`endif
    );

    typedef struct {
        logic ena;
        int   h;
        int   v;
        int   hs;
        int   vs;
        int   de;
        int   ls;
        int   fs;
    } vec_t;

    vec_t vecs[21];
    int   checks = 0;
    int   errors = 0;
    int   found, bad, cnt, vsCnt, deCnt, lsCnt, fsAt;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        enaS = v.ena;
        tick();
    endtask

    task automatic checkAllD(input string tag, input int h, input int v, input int hs,
                             input int vs, input int de, input int ls, input int fs);
        checkOutput({tag, ".hpos"}, int'(hposD), h);
        checkOutput({tag, ".vpos"}, int'(vposD), v);
        checkOutput({tag, ".hsync"}, int'(hsyncD), hs);
        checkOutput({tag, ".vsync"}, int'(vsyncD), vs);
        checkOutput({tag, ".display_on"}, int'(deD), de);
        checkOutput({tag, ".line_start"}, int'(lsD), ls);
        checkOutput({tag, ".frame_start"}, int'(fsD), fs);
    endtask

    task automatic checkAllS(input string tag, input int h, input int v, input int hs,
                             input int vs, input int de, input int ls, input int fs);
        checkOutput({tag, ".hpos"}, int'(hposS), h);
        checkOutput({tag, ".vpos"}, int'(vposS), v);
        checkOutput({tag, ".hsync"}, int'(hsyncS), hs);
        checkOutput({tag, ".vsync"}, int'(vsyncS), vs);
        checkOutput({tag, ".display_on"}, int'(deS), de);
        checkOutput({tag, ".line_start"}, int'(lsS), ls);
        checkOutput({tag, ".frame_start"}, int'(fsS), fs);
    endtask

    // Returns the number of cycles until the next frame_start of dutS, 0 if none.
    task automatic waitSmallFs(input int maxCycles, output int at);
        at = 0;
        for (int n = 0; n < maxCycles && at == 0; n++) begin
            tick();
            if (fsS) at = n + 1;
        end
    endtask

    initial begin
        // dutS vectors: ena applied before the edge, outputs expected after it.
        //          ena   h   v hs vs de ls fs
        vecs[0]  = '{1'b1,  0, 0, 0, 0, 1, 1, 1};
        vecs[1]  = '{1'b1,  1, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{1'b0,  1, 0, 0, 0, 1, 0, 0};
        vecs[3]  = '{1'b0,  1, 0, 0, 0, 1, 0, 0};
        vecs[4]  = '{1'b1,  2, 0, 0, 0, 1, 0, 0};
        vecs[5]  = '{1'b1,  3, 0, 0, 0, 1, 0, 0};
        vecs[6]  = '{1'b1,  4, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{1'b1,  5, 0, 0, 0, 1, 0, 0};
        vecs[8]  = '{1'b1,  6, 0, 0, 0, 1, 0, 0};
        vecs[9]  = '{1'b1,  7, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{1'b1,  8, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{1'b1,  9, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{1'b1, 10, 0, 1, 0, 0, 0, 0};
        vecs[13] = '{1'b0, 10, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{1'b1, 11, 0, 1, 0, 0, 0, 0};
        vecs[15] = '{1'b1, 12, 0, 1, 0, 0, 0, 0};
        vecs[16] = '{1'b1, 13, 0, 0, 0, 0, 0, 0};
        vecs[17] = '{1'b1, 14, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{1'b1,  0, 1, 0, 0, 1, 1, 0};
        vecs[19] = '{1'b0,  0, 1, 0, 0, 1, 0, 0};
        vecs[20] = '{1'b1,  1, 1, 0, 0, 1, 0, 0};

        // Reset values of both instances.
        repeat (3) tick();
        checkAllD("rstD", 799, 524, 1, 1, 0, 0, 0);
        checkAllS("rstS", 14, 11, 0, 0, 0, 0, 0);
`ifdef VGA_TIMING_FRAMECNT_EN
        checkOutput("rstD.frame_cnt", int'(frameCntD), 0);
        checkOutput("rstS.frame_cnt", int'(frameCntS), 0);
`endif

        // First enabled clock after release lands on (0,0) with both strobes.
        rstD = 1'b1;
        tick();
        checkAllD("firstD", 0, 0, 1, 1, 1, 1, 1);

        // One full default line: hsync low only 656..751, display_on falls at 640.
        bad = 0;
        for (int k = 1; k < 800; k++) begin
            tick();
            if (int'(hposD) != k || vposD != 10'd0) bad++;
            if (int'(hsyncD) != ((k >= 656 && k <= 751) ? 0 : 1)) bad++;
            if (int'(deD) != ((k < 640) ? 1 : 0)) bad++;
            if (lsD || fsD || !vsyncD) bad++;
        end
        checkOutput("lineD.badCycles", bad, 0);
        tick();
        checkAllD("line1D", 0, 1, 1, 1, 1, 1, 0);

        // Freeze for 37 cycles at hpos=300 and resume at 301.
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            if (hposD == 10'd300) found = 1;
            else tick();
        end
        checkOutput("reach300D.found", found, 1);
        enaD = 1'b0;
        bad = 0;
        for (int k = 0; k < 37; k++) begin
            tick();
            if (hposD != 10'd300 || vposD != 10'd1) bad++;
            if (!hsyncD || !vsyncD || !deD || lsD || fsD) bad++;
        end
        checkOutput("freezeD.badCycles", bad, 0);
        enaD = 1'b1;
        tick();
        checkOutput("resumeD.hpos", int'(hposD), 301);
        checkOutput("resumeD.vpos", int'(vposD), 1);

        // Asynchronous reset inside the hsync pulse.
        found = 0;
        for (int n = 0; n < 500 && found == 0; n++) begin
            if (hposD == 10'd700) found = 1;
            else tick();
        end
        checkOutput("reach700D.hsync", int'(hsyncD), 0);
        rstD = 1'b0;
        #1;
        checkAllD("midRstD", 799, 524, 1, 1, 0, 0, 0);
        tick();
        rstD = 1'b1;
        tick();
        checkAllD("afterRstD", 0, 0, 1, 1, 1, 1, 1);
        rstD = 1'b0;

        // Small raster: cycle-by-cycle vectors.
        rstS = 1'b1;
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i]);
            checkAllS($sformatf("row%0d", i), vecs[i].h, vecs[i].v, vecs[i].hs,
                      vecs[i].vs, vecs[i].de, vecs[i].ls, vecs[i].fs);
        end

        // One whole small frame (15 x 12 = 180 clocks).
        enaS = 1'b1;
        waitSmallFs(300, fsAt);
        checkOutput("frameS.firstFs", int'(fsAt != 0), 1);
        vsCnt = 0; deCnt = 0; lsCnt = 0; fsAt = 0; bad = 0;
        for (int k = 1; k <= 180; k++) begin
            tick();
            if (vsyncS) vsCnt++;
            if (deS) deCnt++;
            if (lsS) lsCnt++;
            if (fsS && fsAt == 0) fsAt = k;
            if (int'(vsyncS) != ((vposS == 4'd7 || vposS == 4'd8) ? 1 : 0)) bad++;
            if (deS && vposS >= 4'd6) bad++;
        end
        checkOutput("frameS.fsPeriod", fsAt, 180);
        checkOutput("frameS.vsyncCycles", vsCnt, 30);
        checkOutput("frameS.displayCycles", deCnt, 48);
        checkOutput("frameS.lineStarts", lsCnt, 12);
        checkOutput("frameS.badCycles", bad, 0);

        // Asynchronous reset with both syncs active.
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            if (hposS == 4'd11 && vposS == 4'd8) found = 1;
            else tick();
        end
        checkOutput("reachSyncS.hsync", int'(hsyncS), 1);
        checkOutput("reachSyncS.vsync", int'(vsyncS), 1);
        rstS = 1'b0;
        #1;
        checkAllS("midRstS", 14, 11, 0, 0, 0, 0, 0);
`ifdef VGA_TIMING_FRAMECNT_EN
        checkOutput("midRstS.frame_cnt", int'(frameCntS), 0);
`endif
        tick();
        rstS = 1'b1;
        tick();
        checkAllS("afterRstS", 0, 0, 0, 0, 1, 1, 1);

`ifdef VGA_TIMING_FRAMECNT_EN
        // Frame counter: 1 in the first frame, wraps 255 -> 0 -> 1.
        checkOutput("fcnt.first", int'(frameCntS), 1);
        for (int i = 2; i <= 257; i++) begin
            waitSmallFs(200, fsAt);
            if (fsAt == 0) checkOutput($sformatf("fcnt%0d.fsSeen", i), 0, 1);
            else checkOutput($sformatf("fcnt%0d", i), int'(frameCntS), i % 256);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
